// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_cmd_sequencer_if                                         |
// | Description : Command, ALU-drive and result buses of the ALU sequencer.    |
// |               Optional err_cnt signal present when ALU_SEQ_ERR_CNT_EN set. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface alu_cmd_sequencer_if;
  // command channel
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_a;
  logic [4:0] cmd_b;
  logic [1:0] cmd_mode;
  logic [2:0] cmd_op;
  // ALU drive and return
  logic [4:0] alu_a;
  logic [4:0] alu_b;
  logic       alu_a_en;
  logic       alu_b_en;
  logic [2:0] alu_a_op;
  logic [1:0] alu_b_op;
  logic       alu_en;
  logic [5:0] alu_c;
  // result channel and status
  logic       res_valid;
  logic       res_ready;
  logic [5:0] res_data;
  logic       res_err;
  logic       err_drop;
`ifdef ALU_SEQ_ERR_CNT_EN
  logic [7:0] err_cnt;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_op, alu_c, res_ready,
    output cmd_ready, alu_a, alu_b, alu_a_en, alu_b_en, alu_a_op, alu_b_op,
           alu_en, res_valid, res_data, res_err, err_drop, err_cnt
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_op, alu_c, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_a_en, alu_b_en, alu_a_op, alu_b_op,
           alu_en, res_valid, res_data, res_err, err_drop, err_cnt
  );
`else
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_op, alu_c, res_ready,
    output cmd_ready, alu_a, alu_b, alu_a_en, alu_b_en, alu_a_op, alu_b_op,
           alu_en, res_valid, res_data, res_err, err_drop
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_op, alu_c, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_a_en, alu_b_en, alu_a_op, alu_b_op,
           alu_en, res_valid, res_data, res_err, err_drop
  );
`endif
endinterface
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_cmd_sequencer                                            |
// | Description : Buffers ALU commands in a FIFO, issues them one at a time to |
// |               the 5-bit signed ALU and holds each result for downstream.   |
// |               Define ALU_SEQ_ERR_CNT_EN to add the saturating err_cnt.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input wire clk,
  input wire rst_n,
  alu_cmd_sequencer_if.slave bus
);

  localparam int             ENTRY_W   = 15;
  localparam logic [PTR_W:0] C_FULL    = (PTR_W + 1)'(DEPTH);
  localparam logic [1:0]     S_IDLE    = 2'd0;
  localparam logic [1:0]     S_ISSUE   = 2'd1;
  localparam logic [1:0]     S_CAPTURE = 2'd2;

  generate
    if (DEPTH < 2 || (1 << PTR_W) != DEPTH) begin : g_param_check
      $error("alu_cmd_sequencer: DEPTH must be a power of two >= 2 equal to 2**PTR_W");
    end
  endgenerate

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [PTR_W:0]     w_count_nxt;
  logic               r_cmd_ready;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;

  logic [4:0]         w_head_a;
  logic [4:0]         w_head_b;
  logic [1:0]         w_head_mode;
  logic [2:0]         w_head_op;

  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_slot_free;
  logic               w_issue;
  logic               w_drop;
  logic               w_capture;
  logic               w_alu_en;
  logic               w_undef;

  logic [4:0]         r_alu_a;
  logic [4:0]         r_alu_b;
  logic               r_alu_a_en;
  logic               r_alu_b_en;
  logic [2:0]         r_alu_a_op;
  logic [1:0]         r_alu_b_op;

  logic               r_res_valid;
  logic [5:0]         r_res_data;
  logic               r_res_err;
  logic               r_err_drop;

  assign w_push      = bus.cmd_valid && r_cmd_ready;
  assign w_empty     = (r_count == '0);
  assign w_slot_free = !r_res_valid || bus.res_ready;
  assign w_pop       = w_drop || w_issue;
  assign {w_head_a, w_head_b, w_head_mode, w_head_op} = r_mem[r_rd_ptr];

  assign w_count_nxt = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

  // Storage has no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_mode, bus.cmd_op};
    end
  end

  // cmd_ready is registered so it stays low while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count     <= w_count_nxt;
      r_cmd_ready <= (w_count_nxt != C_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && (w_head_mode != 2'b00) && w_slot_free) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_drop    = 1'b0;
    w_issue   = 1'b0;
    w_capture = 1'b0;
    w_alu_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_drop  = !w_empty && (w_head_mode == 2'b00);
        w_issue = !w_empty && (w_head_mode != 2'b00) && w_slot_free;
      end
      S_ISSUE:   w_alu_en  = 1'b1;
      S_CAPTURE: w_capture = 1'b1;
      default: begin
        w_alu_en = 1'b0;
      end
    endcase
  end

  // Undefined ops: A-set op 111, B-set 1 op 11. Mode 11 has none.
  assign w_undef = (r_alu_a_en && !r_alu_b_en && (r_alu_a_op == 3'b111)) ||
                   (!r_alu_a_en && r_alu_b_en && (r_alu_b_op == 2'b11));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_a_en <= 1'b0;
      r_alu_b_en <= 1'b0;
      r_alu_a_op <= '0;
      r_alu_b_op <= '0;
    end else if (w_issue) begin
      r_alu_a    <= w_head_a;
      r_alu_b    <= w_head_b;
      r_alu_a_en <= w_head_mode[0];
      r_alu_b_en <= w_head_mode[1];
      r_alu_a_op <= w_head_op;
      r_alu_b_op <= w_head_op[1:0];
    end
  end

  // A capture takes priority over a same-cycle downstream accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_err_drop  <= 1'b0;
    end else begin
      r_err_drop <= w_drop;
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_data  <= bus.alu_c;
        r_res_err   <= w_undef;
      end else if (r_res_valid && bus.res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  logic       w_err_evt;

  assign w_err_evt = w_drop || (w_capture && w_undef);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_err_evt && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`endif

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_a_en  = r_alu_a_en;
  assign bus.alu_b_en  = r_alu_b_en;
  assign bus.alu_a_op  = r_alu_a_op;
  assign bus.alu_b_op  = r_alu_b_op;
  assign bus.alu_en    = w_alu_en;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_err   = r_res_err;
  assign bus.err_drop  = r_err_drop;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_cmd_sequencer                                         |
// | Description : Directed self-checking bench for alu_cmd_sequencer with a    |
// |               stand-in registered ALU. Honours ALU_SEQ_ERR_CNT_EN.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;
  int   issue_cnt = 0;
  int   drop_cnt  = 0;
  logic [5:0] got_q[$];

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: A-set 000 add, 001 sub; B-set 1 op 11 -> 0; mode 11 op 10 -> A-1.
  function automatic logic [5:0] alu_model(input logic [4:0] a, input logic [4:0] b,
                                           input logic a_en, input logic b_en,
                                           input logic [2:0] a_op, input logic [1:0] b_op);
    logic signed [5:0] sa, sb, r;
    sa = {a[4], a};
    sb = {b[4], b};
    r  = '0;
    if (a_en && !b_en) begin
      case (a_op)
        3'd0: r = sa + sb;
        3'd1: r = sa - sb;
        3'd2: r = sa & sb;
        3'd3: r = sa | sb;
        3'd4: r = sa ^ sb;
        3'd5: r = ~sa;
        3'd6: r = sa;
        default: r = '0;
      endcase
    end else if (!a_en && b_en) begin
      case (b_op)
        2'd0: r = sa + 6'sd1;
        2'd1: r = sb + 6'sd1;
        2'd2: r = sa - sb;
        default: r = '0;
      endcase
    end else if (a_en && b_en) begin
      case (b_op)
        2'd0: r = -sa;
        2'd1: r = -sb;
        2'd2: r = sa - 6'sd1;
        default: r = sb - 6'sd1;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.alu_en) begin
      bus.alu_c <= alu_model(bus.alu_a, bus.alu_b, bus.alu_a_en, bus.alu_b_en,
                             bus.alu_a_op, bus.alu_b_op);
    end
  end

  always @(negedge clk) begin
    if (bus.alu_en)   issue_cnt++;
    if (bus.err_drop) drop_cnt++;
    if (bus.res_valid && bus.res_ready) got_q.push_back(bus.res_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [4:0] b,
                      input logic [1:0] mode, input logic [2:0] op);
    bit done;
    done          = 1'b0;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_mode  = mode;
    bus.cmd_op    = op;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      done = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_res(input string tag);
    int i;
    i = 0;
    while (!bus.res_valid && i < 20) begin
      tick();
      i++;
    end
    check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
  endtask

  task automatic accept();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  // Issue one command into an idle sequencer and check the cycle-by-cycle timing.
  task automatic run_one(input string tag, input logic [4:0] a, input logic [4:0] b,
                         input logic [1:0] mode, input logic [2:0] op,
                         input logic [5:0] exp_data, input logic exp_err);
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_mode  = mode;
    bus.cmd_op    = op;
    bus.cmd_valid = 1'b1;
    check({tag, "_rdy"}, 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    check({tag, "_en_t0"}, 32'(bus.alu_en), 32'd0);
    tick();
    check({tag, "_en_t1"}, 32'(bus.alu_en), 32'd1);
    check({tag, "_alu_a"}, 32'(bus.alu_a), 32'(a));
    check({tag, "_alu_b"}, 32'(bus.alu_b), 32'(b));
    check({tag, "_a_en"}, 32'(bus.alu_a_en), 32'(mode[0]));
    check({tag, "_b_en"}, 32'(bus.alu_b_en), 32'(mode[1]));
    check({tag, "_a_op"}, 32'(bus.alu_a_op), 32'(op));
    check({tag, "_b_op"}, 32'(bus.alu_b_op), 32'(op[1:0]));
    tick();
    check({tag, "_en_t2"}, 32'(bus.alu_en), 32'd0);
    check({tag, "_val_t2"}, 32'(bus.res_valid), 32'd0);
    tick();
    check({tag, "_val_t3"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.res_data), 32'(exp_data));
    check({tag, "_err"}, 32'(bus.res_err), 32'(exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int issue0, drop0, stale;
    logic [5:0] exp_drain [6];

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_mode  = '0;
    bus.cmd_op    = '0;
    bus.res_ready = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_alu_en", 32'(bus.alu_en), 32'd0);
    check("rst_err_drop", 32'(bus.err_drop), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // 3 + 4 = 7, then -16 - 1 = -17
    run_one("add", 5'd3, 5'd4, 2'b01, 3'b000, 6'h07, 1'b0);
    accept();
    check("add_clr", 32'(bus.res_valid), 32'd0);
    run_one("dec", 5'b10000, 5'd5, 2'b11, 3'b010, 6'h2F, 1'b0);
    accept();

    // mode-00 command sandwiched between two valid ones
    got_q.delete();
    issue0 = issue_cnt;
    drop0  = drop_cnt;
    bus.res_ready = 1'b1;
    push(5'd5, 5'd5, 2'b01, 3'b000);
    push(5'd9, 5'd9, 2'b00, 3'b000);
    push(5'd1, 5'd2, 2'b01, 3'b001);
    repeat (12) tick();
    bus.res_ready = 1'b0;
    check("drop_nres", got_q.size(), 32'd2);
    if (got_q.size() >= 2) begin
      check("drop_r0", 32'(got_q[0]), 32'h0A);
      check("drop_r1", 32'(got_q[1]), 32'h3F);
    end
    check("drop_pulses", drop_cnt - drop0, 32'd1);
    check("drop_issues", issue_cnt - issue0, 32'd2);
`ifdef ALU_SEQ_ERR_CNT_EN
    check("errcnt_drop", 32'(bus.err_cnt), 32'd1);
`endif

    // undefined B-set 1 op, result held while downstream stalls
    run_one("undef", 5'd2, 5'd5, 2'b10, 3'b011, 6'h00, 1'b1);
    push(5'd1, 5'd1, 2'b01, 3'b000);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(bus.res_valid), 32'd1);
      check("hold_data", 32'(bus.res_data), 32'h00);
      check("hold_no_issue", 32'(bus.alu_en), 32'd0);
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("hold_clr", 32'(bus.res_valid), 32'd0);
    check("hold_issue", 32'(bus.alu_en), 32'd1);
    tick();
    tick();
    check("next_valid", 32'(bus.res_valid), 32'd1);
    check("next_data", 32'(bus.res_data), 32'h02);
    check("next_err", 32'(bus.res_err), 32'd0);
`ifdef ALU_SEQ_ERR_CNT_EN
    check("errcnt_undef", 32'(bus.err_cnt), 32'd2);
`endif
    accept();

    // fill: slot occupied, four commands fill the FIFO, fifth stalls
    run_one("pre", 5'd6, 5'b11101, 2'b01, 3'b001, 6'h09, 1'b0);
    issue0 = issue_cnt;
    for (int k = 1; k <= 4; k++) push(5'(k), 5'(k), 2'b01, 3'b000);
    check("full_ready", 32'(bus.cmd_ready), 32'd0);
    exp_drain = '{6'h09, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A};
    fork
      push(5'd5, 5'd5, 2'b01, 3'b000);
      begin
        for (int i = 0; i < 3; i++) begin
          check("stall_ready", 32'(bus.cmd_ready), 32'd0);
          tick();
        end
        for (int i = 0; i < 6; i++) begin
          wait_res("drain");
          check("drain_data", 32'(bus.res_data), 32'(exp_drain[i]));
          check("drain_issues", issue_cnt - issue0, 32'(i));
          accept();
        end
      end
    join
    check("fill_issues", issue_cnt - issue0, 32'd5);

    // asynchronous reset while a command is in ISSUE and another is buffered
    push(5'd7, 5'd1, 2'b01, 3'b000);
    push(5'd2, 5'd2, 2'b01, 3'b000);
    check("arst_pre_en", 32'(bus.alu_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_alu_en", 32'(bus.alu_en), 32'd0);
    check("arst_alu_a", 32'(bus.alu_a), 32'd0);
    check("arst_alu_b", 32'(bus.alu_b), 32'd0);
    check("arst_a_en", 32'(bus.alu_a_en), 32'd0);
    check("arst_a_op", 32'(bus.alu_a_op), 32'd0);
    check("arst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("arst_res_valid", 32'(bus.res_valid), 32'd0);
    check("arst_res_data", 32'(bus.res_data), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("arst_rel_ready", 32'(bus.cmd_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.res_valid || bus.alu_en) stale++;
      tick();
    end
    check("arst_no_stale", stale, 32'd0);
`ifdef ALU_SEQ_ERR_CNT_EN
    check("arst_errcnt", 32'(bus.err_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
